tdm_pkt_tx: RTL and testbench
=============================

Name: tdm_pkt_tx

Overview:
- Transmit-side companion of the 6x6 switch ingress.
- Accepts six independent per-port byte streams and queues each in its own FIFO.
- Drives the switch's single time-multiplexed byte lane: input_wire, input_new_packet, input_data.
- Its slot counter is reset by the same rst edge as the switch's input_sel counter, so port k's byte is on the lane exactly when the switch's counter equals k.

Parameters:
- DATA_WIDTH, 8, byte lane width.
- NUM_QUEUES, 6, number of ports and active slots; slots 0..NUM_QUEUES-1.
- SLOT_BITS, 8, slot counter width; period is 2^SLOT_BITS = 256 cycles, matching the switch's free-running 8-bit counter.
- FIFO_DEPTH, 16, entries per port FIFO; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- s_valid  in  NUM_QUEUES  per-port byte valid.
- s_ready  out  NUM_QUEUES  per-port ready; equals FIFO not-full.
- s_sop  in  NUM_QUEUES  per-port first byte of packet.
- s_data  in  NUM_QUEUES*DATA_WIDTH  per-port byte; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- tx_wire  out  1  lane byte valid; connects to switch input_wire.
- tx_new_packet  out  1  lane start-of-packet; connects to switch input_new_packet.
- tx_data  out  DATA_WIDTH  lane byte; connects to switch input_data.
- tx_slot  out  SLOT_BITS  current slot number, for debug and alignment checks.
- fifo_empty  out  NUM_QUEUES  per-port FIFO empty flag.

Behaviour:
- Reset (rst=0, async):
  - slot_cnt=0; all FIFOs flushed (pointers 0).
  - tx_wire=0, tx_new_packet=0, tx_data=0.
  - s_ready=all 1s, fifo_empty=all 1s.
  - Reset mid-packet discards all queued bytes; nothing is replayed after reset.
- Slot counter:
  - slot_cnt increments every clk and wraps from 2^SLOT_BITS-1 to 0.
  - tx_slot = slot_cnt.
- Push:
  - On a clk edge with s_valid[k] && s_ready[k], the FIFO for port k stores {s_sop[k], byte}.
  - s_ready[k] = !full[k], computed from registered pointers only.
  - At full, push is refused even if a pop happens on the same edge.
  - The upstream source must hold s_valid, s_sop and s_data until it sees ready.
- Load / pop, with registered outputs:
  - Define nxt = slot_cnt+1 mod period.
  - At each edge, if nxt < NUM_QUEUES and FIFO nxt is non-empty: pop one entry and load tx_wire=1, tx_new_packet=entry.sop, tx_data=entry.byte.
  - Otherwise load tx_wire=0, tx_new_packet=0, tx_data=0.
  - Result: during the cycle where slot_cnt==k, the lane carries port k's byte or idle. Non-slot cycles (slot_cnt 6..255) are always idle.
- Emptiness is evaluated on pre-edge state:
  - A byte pushed on the same edge as its port's load is not sent in that slot; it waits one full period.
  - There is no bypass path.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
- Throughput: at most 1 byte per port per period (256 cycles). Per-port FIFOs are independent, so there is no head-of-line blocking across ports.
- Packet boundaries:
  - No framing checks; the sop flag is forwarded verbatim.
  - An end of packet is implicit, marked by the next sop or by an idle slot, as the switch's deserialiser expects.
- Latency: push to lane appearance takes 1 to 256 cycles, depending on slot phase.

Decomposition:
- Shared include holds:
  - NUM_QUEUES and SLOT_BITS defaults, shared with the switch top so the slot period cannot drift.
  - The FIFO entry layout {sop, byte}, DATA_WIDTH+1 bits.
- Sub-module tdm_byte_fifo:
  - Synchronous FIFO, async active-low reset.
  - Ports: push, pop, din, dout, full, empty.
  - Uses pointers with an extra wrap bit.
  - Instantiated NUM_QUEUES times in a generate loop.
- The top holds slot_cnt, pop select and the output registers.

Test Plan:
- Release reset with no traffic, run 600 cycles -> tx_wire=0 always, tx_slot sequence 0,1,...,255,0; s_ready=6'b111111.
- Push port 2 bytes 0xA1(sop),0xA2,0xA3 at cycle 10 -> lane shows {1,1,0xA1} at slot_cnt==2 of the next period, then 0xA2 and 0xA3 (new_packet=0) at slot 2 of the following two periods; all other cycles idle.
- Push one byte to each of ports 0..5 (values 0x10..0x15, sop=1) -> within one period, slots 0..5 carry 0x10..0x15 in consecutive cycles with new_packet=1.
- Fill port 4 with 16 bytes while it is not served -> s_ready[4]=0 after the 16th push. A 17th byte held valid is accepted only on the edge after the slot-4 pop; no byte is lost or duplicated.
- Push port 0 on the edge where slot_cnt transitions 255->0 -> byte not sent in that slot, sent at slot 0 of the next period (256 cycles later).
- Assert rst with 5 bytes queued on port 1 mid-packet -> outputs 0 immediately (async), FIFO empty after release, no port-1 byte ever appears on the lane; the counter restarts at 0 in step with the switch.

Source files
------------

// File: rtl/tdm_pkt_tx_pkg.sv
// tdm_pkt_tx_pkg
// Shared constants and types for the TDM transmit slice and the switch ingress.
// The slot count and period come from here so both ends use the same lane timing.
// The FIFO entry layout {sop, byte} is also defined here.
package tdm_pkt_tx_pkg;

    localparam int TDM_DATA_WIDTH = 8;
    localparam int TDM_NUM_QUEUES = 6;
    localparam int TDM_SLOT_BITS  = 8;
    localparam int TDM_FIFO_DEPTH = 16;

    // One queued lane byte. The sop flag sits above the data byte.
    typedef struct packed {
        logic                      sop;
        logic [TDM_DATA_WIDTH-1:0] data;
    } tdm_entry_t;

    localparam int TDM_ENTRY_WIDTH = $bits(tdm_entry_t);

endpackage

// File: rtl/tdm_byte_fifo.sv
// tdm_byte_fifo
// Synchronous single-clock FIFO for one port's {sop, byte} entries.
// Reads are fall-through: dout always shows the head entry.
// Ports:
//   clk, rst   clock, asynchronous active-low reset (flushes pointers)
//   push, din  write request and entry; ignored while full
//   pop, dout  read request and head entry; ignored while empty
//   full       no free entries
//   empty      no stored entries
module tdm_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra top pointer bit tells full apart from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset. Clearing the pointers is enough to discard the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tdm_pkt_tx.sv
// tdm_pkt_tx
// Transmit side of the switch's time-multiplexed ingress lane.
// Each port's byte stream is queued in its own FIFO. Port k's head entry goes
// onto the lane in the cycle where the free-running slot counter equals k.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   s_valid/s_ready   per-port handshake; ready is FIFO not-full
//   s_sop, s_data     per-port start-of-packet flag and byte (port k at k*DATA_WIDTH)
//   tx_wire           lane byte valid       -> switch input_wire
//   tx_new_packet     lane start-of-packet  -> switch input_new_packet
//   tx_data           lane byte             -> switch input_data
//   tx_slot           current slot number
//   fifo_empty        per-port FIFO empty flag
module tdm_pkt_tx
    import tdm_pkt_tx_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_WIDTH,
    parameter int NUM_QUEUES = TDM_NUM_QUEUES,
    parameter int SLOT_BITS  = TDM_SLOT_BITS,
    parameter int FIFO_DEPTH = TDM_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_QUEUES-1:0]            s_valid,
    output logic [NUM_QUEUES-1:0]            s_ready,
    input  logic [NUM_QUEUES-1:0]            s_sop,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] s_data,
    output logic                             tx_wire,
    output logic                             tx_new_packet,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic [SLOT_BITS-1:0]             tx_slot,
    output logic [NUM_QUEUES-1:0]            fifo_empty
);

    logic [SLOT_BITS-1:0]  slot_cnt;
    logic [SLOT_BITS-1:0]  nxt;
    logic [NUM_QUEUES-1:0] full;
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] pop;
    logic [DATA_WIDTH:0]   head [NUM_QUEUES];
    logic [DATA_WIDTH:0]   sel_entry;
    logic                  sel_valid;

    // The output registers are loaded for the coming slot, so the pop
    // selection looks one slot ahead. Wrap-around comes from the counter width.
    assign nxt        = slot_cnt + SLOT_BITS'(1);
    assign tx_slot    = slot_cnt;
    assign s_ready    = ~full;
    assign fifo_empty = empty;

    for (genvar k = 0; k < NUM_QUEUES; k++) begin : g_port
        // Emptiness is taken from pre-edge pointers. A byte pushed on its
        // own slot's load edge is not bypassed and waits a full period.
        assign pop[k] = (nxt == SLOT_BITS'(k)) && !empty[k];

        tdm_byte_fifo #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (s_valid[k]),
            .pop   (pop[k]),
            .din   ({s_sop[k], s_data[k*DATA_WIDTH +: DATA_WIDTH]}),
            .dout  (head[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    // At most one pop bit is set because nxt matches only one port index.
    always_comb begin
        sel_valid = 1'b0;
        sel_entry = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            if (pop[k]) begin
                sel_valid = 1'b1;
                sel_entry = head[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt      <= '0;
            tx_wire       <= 1'b0;
            tx_new_packet <= 1'b0;
            tx_data       <= '0;
        end else begin
            slot_cnt      <= nxt;
            tx_wire       <= sel_valid;
            tx_new_packet <= sel_entry[DATA_WIDTH];
            tx_data       <= sel_entry[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_tdm_pkt_tx.sv
// tb_tdm_pkt_tx
// Scoreboard bench for tdm_pkt_tx. A reference model keeps one queue per port
// and a slot number. It pushes the expected lane bytes into a scoreboard queue.
// A separate monitor pops that queue whenever the DUT drives a lane byte.
module tb_tdm_pkt_tx;
    import tdm_pkt_tx_pkg::*;

    localparam int NQ     = 6;
    localparam int DW     = 8;
    localparam int DEPTH  = 16;
    localparam int PERIOD = 256;

    typedef struct {
        int         slot;
        logic       sop;
        logic [7:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NQ-1:0]     s_valid;
    logic [NQ-1:0]     s_ready;
    logic [NQ-1:0]     s_sop;
    logic [NQ*DW-1:0]  s_data;
    logic              tx_wire;
    logic              tx_new_packet;
    logic [DW-1:0]     tx_data;
    logic [7:0]        tx_slot;
    logic [NQ-1:0]     fifo_empty;

    tdm_entry_t        pend [NQ][$];
    tdm_entry_t        mq   [NQ][$];
    exp_t              expq [$];
    logic [NQ-1:0]     acc = '0;
    int                m_slot = 0;
    int                n_checks = 0;
    int                n_pass = 0;

    tdm_pkt_tx u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sop         (s_sop),
        .s_data        (s_data),
        .tx_wire       (tx_wire),
        .tx_new_packet (tx_new_packet),
        .tx_data       (tx_data),
        .tx_slot       (tx_slot),
        .fifo_empty    (fifo_empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input int port, input logic sop, input logic [7:0] data);
        tdm_entry_t e;
        e.sop  = sop;
        e.data = data;
        pend[port].push_back(e);
    endtask

    // Reference model: one lane slot per cycle. Slot k serves port k's head
    // entry when that port had a byte before the edge. A port accepts a byte
    // when it held fewer than DEPTH entries before the edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int k = 0; k < NQ; k++) mq[k].delete();
                acc    = '0;
                m_slot = 0;
            end else begin
                logic [NQ-1:0] accept;
                int            nxt;
                for (int k = 0; k < NQ; k++)
                    accept[k] = s_valid[k] && (mq[k].size() < DEPTH);
                nxt = (m_slot + 1) % PERIOD;
                if (nxt < NQ && mq[nxt].size() > 0) begin
                    tdm_entry_t e;
                    exp_t       x;
                    e      = mq[nxt].pop_front();
                    x.slot = nxt;
                    x.sop  = e.sop;
                    x.data = e.data;
                    expq.push_back(x);
                end
                for (int k = 0; k < NQ; k++) begin
                    if (accept[k]) begin
                        tdm_entry_t e;
                        e.sop  = s_sop[k];
                        e.data = s_data[k*DW +: DW];
                        mq[k].push_back(e);
                    end
                end
                acc    = accept;
                m_slot = nxt;
            end
        end
    end

    // Upstream driver: holds each port's head byte until the model reports it was accepted.
    initial begin
        s_valid = '0;
        s_sop   = '0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NQ; k++) begin
                if (acc[k] && pend[k].size() > 0) begin
                    tdm_entry_t d;
                    d = pend[k].pop_front();
                end
                if (pend[k].size() > 0) begin
                    s_valid[k]          = 1'b1;
                    s_sop[k]            = pend[k][0].sop;
                    s_data[k*DW +: DW]  = pend[k][0].data;
                end else begin
                    s_valid[k]          = 1'b0;
                    s_sop[k]            = 1'b0;
                    s_data[k*DW +: DW]  = '0;
                end
            end
            acc = '0;
        end
    end

    // Monitor: compares the slot, flags and lane bytes in mid-cycle.
    initial begin
        forever begin
            logic [NQ-1:0] m_ready;
            logic [NQ-1:0] m_empty;
            @(negedge clk);
            for (int k = 0; k < NQ; k++) begin
                m_ready[k] = mq[k].size() < DEPTH;
                m_empty[k] = mq[k].size() == 0;
            end
            checkOutput("tx_slot", 32'(tx_slot), m_slot);
            checkOutput("s_ready", 32'(s_ready), 32'(m_ready));
            checkOutput("fifo_empty", 32'(fifo_empty), 32'(m_empty));
            if (tx_wire) begin
                if (expq.size() == 0) begin
                    checkOutput("lane_unexpected", 32'(tx_wire), 32'(0));
                end else begin
                    exp_t x;
                    x = expq.pop_front();
                    checkOutput("lane_byte", {15'd0, tx_slot, tx_new_packet, tx_data},
                                {15'd0, 8'(x.slot), x.sop, x.data});
                end
            end else begin
                checkOutput("lane_idle", {23'd0, tx_new_packet, tx_data}, 32'(0));
            end
        end
    end

    task automatic waitSlot(input int target);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (m_slot != target && n < 2 * PERIOD);
        if (m_slot != target) checkOutput("wait_slot_timeout", m_slot, target);
    endtask

    task automatic waitDrain(input int max_cycles);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
            done = (expq.size() == 0);
            for (int k = 0; k < NQ; k++)
                if (pend[k].size() != 0 || mq[k].size() != 0) done = 0;
        end
        checkOutput("drain", 32'(done), 32'(1));
    endtask

    initial begin
        rst = 1'b0;
        #17;
        checkOutput("reset_tx_wire", 32'(tx_wire), 32'(0));
        checkOutput("reset_tx_data", {23'd0, tx_new_packet, tx_data}, 32'(0));
        checkOutput("reset_s_ready", 32'(s_ready), 32'h3f);
        checkOutput("reset_fifo_empty", 32'(fifo_empty), 32'h3f);
        @(negedge clk);
        #2;
        rst = 1'b1;
        $display("[TB] reset released, idle run");

        repeat (600) @(posedge clk);

        $display("[TB] port 2 three-byte packet");
        waitSlot(10);
        applyStimulus(2, 1'b1, 8'hA1);
        applyStimulus(2, 1'b0, 8'hA2);
        applyStimulus(2, 1'b0, 8'hA3);
        waitDrain(4 * PERIOD);

        $display("[TB] one byte on every port");
        waitSlot(100);
        for (int k = 0; k < NQ; k++) applyStimulus(k, 1'b1, 8'(8'h10 + k));
        waitDrain(2 * PERIOD);

        $display("[TB] fill port 4");
        waitSlot(10);
        for (int i = 0; i < 17; i++) applyStimulus(4, (i == 0), 8'(8'h40 + i));
        repeat (18) @(posedge clk);
        #1;
        checkOutput("port4_full", 32'(s_ready[4]), 32'(0));
        waitDrain(18 * PERIOD);

        $display("[TB] port 0 push on slot wrap");
        waitSlot(255);
        applyStimulus(0, 1'b1, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap_still_queued", 32'(fifo_empty[0]), 32'(0));
        waitDrain(2 * PERIOD);

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < NQ; k++)
                if ($urandom_range(0, 149) == 0)
                    applyStimulus(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
        waitDrain(24 * PERIOD);

        $display("[TB] reset with port 1 mid-packet");
        waitSlot(20);
        for (int i = 0; i < 6; i++) applyStimulus(1, (i == 0), 8'(8'hB0 + i));
        waitSlot(1);
        @(negedge clk);
        #1;
        checkOutput("pre_reset_lane", 32'(tx_wire), 32'(1));
        checkOutput("pre_reset_leftover", expq.size(), 0);
        rst = 1'b0;
        #1;
        checkOutput("async_tx_wire", 32'(tx_wire), 32'(0));
        checkOutput("async_tx_data", {23'd0, tx_new_packet, tx_data}, 32'(0));
        checkOutput("async_tx_slot", 32'(tx_slot), 32'(0));
        checkOutput("async_fifo_empty", 32'(fifo_empty), 32'h3f);
        checkOutput("async_s_ready", 32'(s_ready), 32'h3f);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (600) @(posedge clk);

        #1;
        checkOutput("scoreboard_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
